seq_intersect_monitor: RTL and testbench

- Synthesizable hardware checker for the intersect property on three single-bit signals a, b, c.
- Property: on a rise of b, a[*A_LEN] must hold over exactly the same cycles as b[*B_LEN] ##1 c.
- Sits directly downstream of the a/b/c stimulus source; produces pass/fail pulses and counters for the bench and on-chip debug.
- Gives an RTL-checkable equivalent of the assertion, with explicit early-fail timing.

---
 rtl/seq_chk_pkg.sv | 25 ++
 rtl/sat_counter.sv | 22 ++
 rtl/seq_intersect_monitor.sv | 103 ++++++++++
 tb/tb_seq_intersect_monitor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// Shared types and index helpers for the a[*A_LEN] intersect b[*B_LEN] ##1 c checker.
package seq_chk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  // Final sample index L of an attempt: max(A_LEN, B_LEN+1) - 1.
  function automatic int calc_last(input int a_len, input int b_len);
    return ((a_len > b_len + 1) ? a_len : b_len + 1) - 1;
  endfunction

  // Index at which a fully-good attempt ends when lengths disagree.
  function automatic int calc_short_end(input int a_len, input int b_len);
    return ((a_len < b_len + 1) ? a_len : b_len + 1) - 1;
  endfunction

  function automatic int idx_width(input int last);
    return (last < 1) ? 1 : $clog2(last + 1);
  endfunction

  localparam int IDX_W_DEF = idx_width(calc_last(4, 3));

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_intersect_monitor.sv
// Checker for: $rose(b) |-> a[*A_LEN] intersect (b[*B_LEN] ##1 c), with early fail
// and registered one-cycle pass/fail pulses plus saturating counters.
module seq_intersect_monitor
  import seq_chk_pkg::*;
#(
  parameter int A_LEN = 4,
  parameter int B_LEN = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int LAST    = calc_last(A_LEN, B_LEN);
  localparam int IDX_W   = idx_width(LAST);
  localparam bit MATCH   = (A_LEN == B_LEN + 1);
  localparam int END_IDX = MATCH ? LAST : calc_short_end(A_LEN, B_LEN);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] k, k_nxt, cur_k;
  logic [31:0]      k_ext;
  logic             b_prev;
  logic             trigger, active, a_ok, bc_ok, good;
  logic             pass_d, fail_d;

  assign trigger = (state == IDLE) && en && b && !b_prev;
  assign active  = (state == CHECK) || trigger;
  // The trigger edge itself is sample 0, so IDLE evaluates with index 0.
  assign cur_k   = (state == CHECK) ? k : '0;
  assign k_ext   = 32'(cur_k);

  assign a_ok  = (k_ext < 32'(A_LEN)) ? a : 1'b1;
  assign bc_ok = (k_ext < 32'(B_LEN))  ? b :
                 (k_ext == 32'(B_LEN)) ? c : 1'b1;
  assign good  = a_ok && bc_ok;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    if (active) begin
      if (!good) begin
        fail_d    = 1'b1;
        state_nxt = IDLE;
        k_nxt     = '0;
      end else if (k_ext == 32'(END_IDX)) begin
        pass_d    = MATCH;
        fail_d    = !MATCH;
        state_nxt = IDLE;
        k_nxt     = '0;
      end else begin
        state_nxt = CHECK;
        k_nxt     = cur_k + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      b_prev <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      b_prev <= b;
      pass   <= pass_d;
      fail   <= fail_d;
    end
  end

  assign busy = (state == CHECK);

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (pass),
    .cnt   (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (fail),
    .cnt   (fail_cnt)
  );

endmodule

// File: tb/tb_seq_intersect_monitor.sv
// Directed bench for seq_intersect_monitor: default, length-mismatch and narrow-counter instances.
module tb_seq_intersect_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;

  logic        busy, pass, fail;
  logic [15:0] pass_cnt, fail_cnt;
  logic        mm_busy, mm_pass, mm_fail;
  logic [15:0] mm_pass_cnt, mm_fail_cnt;
  logic        st_busy, st_pass, st_fail;
  logic [2:0]  st_pass_cnt, st_fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_intersect_monitor #(.A_LEN(4), .B_LEN(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .busy(busy), .pass(pass), .fail(fail), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  seq_intersect_monitor #(.A_LEN(5), .B_LEN(3), .CNT_W(16)) dut_mm (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .busy(mm_busy), .pass(mm_pass), .fail(mm_fail), .pass_cnt(mm_pass_cnt),
    .fail_cnt(mm_fail_cnt)
  );

  seq_intersect_monitor #(.A_LEN(4), .B_LEN(3), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .busy(st_busy), .pass(st_pass), .fail(st_fail), .pass_cnt(st_pass_cnt),
    .fail_cnt(st_fail_cnt)
  );

  typedef struct {
    logic        a, b, c, en;
    logic        busy, pass, fail, mm_fail;
    logic [15:0] pcnt, fcnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies inputs for one rising edge, then samples just after it.
  task automatic drive(input logic av, input logic bv, input logic cv, input logic env);
    a = av; b = bv; c = cv; en = env;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic av, bv, cv, env, ebusy, epass, efail, emm,
                     input int pc, input int fc);
    vec_t v;
    v.a = av; v.b = bv; v.c = cv; v.en = env;
    v.busy = ebusy; v.pass = epass; v.fail = efail; v.mm_fail = emm;
    v.pcnt = 16'(pc); v.fcnt = 16'(fc);
    tbl.push_back(v);
  endtask

  task automatic pass_seq();
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 1);
    drive(1, 0, 1, 1);
    check("seq_pass_pulse", 32'(pass), 32'd1);
  endtask

  initial begin
    //   a  b  c  en busy pass fail mmf pcnt fcnt
    // full pass, then back-to-back second pass (b rises at edge after deciding edge)
    add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 2, 0);
    // a drops at sample 2: early fail
    add(1, 1, 0, 1, 1, 0, 0, 0, 2, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0, 2, 0);
    add(0, 1, 0, 1, 0, 0, 1, 1, 2, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 2, 1);
    // c high at sample 1 is ignored, c low at sample 3 fails
    add(1, 1, 0, 1, 1, 0, 0, 0, 2, 1);
    add(1, 1, 1, 1, 1, 0, 0, 0, 2, 1);
    add(1, 1, 0, 1, 1, 0, 0, 0, 2, 1);
    add(1, 0, 0, 1, 0, 0, 1, 1, 2, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 2, 2);
    // rise of b while en low: no attempt, and b_prev still follows b
    add(1, 1, 0, 0, 0, 0, 0, 0, 2, 2);
    add(1, 1, 0, 1, 0, 0, 0, 0, 2, 2);
    add(0, 0, 0, 1, 0, 0, 0, 0, 2, 2);
    // bad sample 0: fail straight from IDLE, busy never rises
    add(0, 1, 0, 1, 0, 0, 1, 1, 2, 2);
    add(0, 0, 0, 1, 0, 0, 0, 0, 2, 3);

    a = 0; b = 0; c = 0; en = 1; clr = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    rst_n = 1;
    drive(0, 0, 0, 1);
    check("idle_no_pulse", 32'({busy, pass, fail}), 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].en);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
      check($sformatf("v%0d_fail", i), 32'(fail), 32'(tbl[i].fail));
      check($sformatf("v%0d_mm_fail", i), 32'(mm_fail), 32'(tbl[i].mm_fail));
      check($sformatf("v%0d_mm_pass", i), 32'(mm_pass), 32'd0);
      check($sformatf("v%0d_pass_cnt", i), 32'(pass_cnt), 32'(tbl[i].pcnt));
      check($sformatf("v%0d_fail_cnt", i), 32'(fail_cnt), 32'(tbl[i].fcnt));
    end

    // asynchronous reset with the attempt at k=2
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 1);
    check("mid_busy", 32'(busy), 32'd1);
    b = 0; a = 0;
    #2 rst_n = 0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("mid_rst_fail_cnt", 32'(fail_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1);
      check($sformatf("post_rst_pulse%0d", i), 32'({pass, fail}), 32'd0);
    end
    check("post_rst_fail_cnt", 32'(fail_cnt), 32'd0);

    // nine fails: 3-bit counter stops at 7, 16-bit counter keeps going
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 1);
      check($sformatf("sat_fail%0d", i), 32'(st_fail), 32'd1);
      drive(0, 0, 0, 1);
    end
    check("sat_fail_cnt", 32'(st_fail_cnt), 32'd7);
    check("wide_fail_cnt", 32'(fail_cnt), 32'd9);

    // clr in the same cycle as a pass pulse wins over the increment
    pass_seq();
    drive(0, 0, 0, 1);
    check("pre_clr_pass_cnt", 32'(pass_cnt), 32'd1);
    pass_seq();
    clr = 1;
    drive(0, 0, 0, 1);
    clr = 0;
    check("clr_pass_cnt", 32'(pass_cnt), 32'd0);
    check("clr_fail_cnt", 32'(fail_cnt), 32'd0);
    check("clr_sat_fail_cnt", 32'(st_fail_cnt), 32'd0);
    drive(0, 0, 0, 1);
    check("clr_hold_pass_cnt", 32'(pass_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
